rams_sdp_taps: RTL and testbench
================================

Name: rams_sdp_taps

Overview:
- Single-clock simple-dual-port RAM: one write port, one read port returning NTAPS consecutive words (raddr, raddr+1, …, raddr+NTAPS-1) per read.
- Successor to the two-word fixed-tap RAM used by the UART buffering path. Adds parametrised tap count, an optional output register stage, read-valid tracking, a selectable read-during-write policy and asynchronous reset of the output pipeline.
- Sits between AXI-Stream framing logic and the UART shift engines wherever multi-word look-ahead is needed.

Parameters:
- DWIDTH, 16, data word width in bits (≥1).
- ADDRWIDTH, 10, address width; depth = 2**ADDRWIDTH words.
- NTAPS, 2, consecutive words returned per read (1..8).
- OREG, 1, 0 = data registered once (latency 1); 1 = extra output register (latency 2).
- BYPASS, 0, 0 = read-old on same-address collision; 1 = forward write data on collision.

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  asynchronous active-high reset of the output pipeline; RAM contents are not cleared.
- en  in  1  global clock enable; low freezes writes, reads and the whole pipeline.
- we  in  1  write strobe, qualified by en.
- waddr  in  ADDRWIDTH  write address.
- di  in  DWIDTH  write data.
- rd_en  in  1  read request, qualified by en.
- raddr  in  ADDRWIDTH  base read address.
- dout  out  NTAPS*DWIDTH  tap i at dout[i*DWIDTH +: DWIDTH], word at raddr+i.
- dout_valid  out  1  high while dout holds the result of a read request.

Behaviour:
- Reset: dout = 0, dout_valid = 0, all internal pipeline registers = 0, effective immediately on rst assertion and independent of clk. RAM array is untouched. Reset asserted mid-read discards the read; no valid is produced for it after release.
- Write: on a clk edge with en=1 and we=1, RAM[waddr] <= di.
- Read stage 1, on a clk edge with en=1:
  - tap register i <= RAM[(raddr+i) mod 2**ADDRWIDTH]; the address sum is truncated to ADDRWIDTH bits, so wrap-around is natural.
  - v1 <= rd_en.
  - Tap registers load on every enabled edge, even when rd_en=0. Only the valid bit qualifies the data.
- Stage 2, present only when OREG=1: on each en=1 edge, dout <= tap registers and dout_valid <= v1. When OREG=0, dout and dout_valid are driven directly from stage 1.
- Latency from rd_en sampled to dout_valid high: 1 edge (OREG=0) or 2 edges (OREG=1). Full throughput: one read per cycle, back-to-back.
- en=0: no write; all pipeline registers hold; dout and dout_valid remain stable for any number of cycles.
- Collision (we=1, en=1, rd_en=1, waddr equal to any tap address on the same edge):
  - BYPASS=0: that tap returns the pre-write contents.
  - BYPASS=1: that tap returns di.
  - Non-colliding taps are unaffected. Several taps can only collide at once if NTAPS exceeds the depth, which is disallowed.
- Reading a never-written address returns undefined data. The bench must not check it.
- Write and read ports are independent; simultaneous write and read to different addresses have no interaction.

Test Plan:
- ADDRWIDTH=4, NTAPS=2, OREG=1: write RAM[a]=a*3 for a=0..15. Then rd_en=1, raddr=4 for one cycle → two edges later dout_valid=1 for exactly one cycle, tap0=12, tap1=15.
- Wrap-around, same contents: raddr=15 → tap0=45, tap1=0. NTAPS=4, raddr=14 → taps 42, 45, 0, 3.
- Collision, RAM[7]=21, same-edge we=1 waddr=8 di=0xAAAA with rd_en=1 raddr=7:
  - BYPASS=0 → tap0=21, tap1=24.
  - BYPASS=1 → tap0=21, tap1=0xAAAA.
  - In both cases a subsequent read of 8 returns 0xAAAA.
- Stall: issue reads at raddr=2,3,4 on consecutive cycles, holding en=0 for 3 cycles after the second request → dout and dout_valid frozen during the stall. Results {6,9}, {9,12}, {12,15} then appear in order, each exactly once. A write attempted with en=0 does not modify RAM.
- Reset mid-operation: assert rst asynchronously (between edges) one cycle after a read request → dout=0 and dout_valid=0 immediately; no valid appears after release. Re-reading raddr=4 afterwards returns {12,15}, proving contents were retained.
- OREG=0 back-to-back reads raddr=0..15 → dout_valid high continuously starting one edge after the first request; each tap0 equals raddr*3.

Source files
------------

// File: rtl/rams_sdp_taps.sv
// Simple-dual-port RAM returning NTAPS consecutive words per read.
// Ports: clk, rst, en, we, waddr, di, rd_en, raddr, dout, dout_valid.
module rams_sdp_taps #(
  parameter int DWIDTH    = 16,
  parameter int ADDRWIDTH = 10,
  parameter int NTAPS     = 2,
  parameter int OREG      = 1,
  parameter int BYPASS    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDRWIDTH-1:0]    waddr,
  input  logic [DWIDTH-1:0]       di,
  input  logic                    rd_en,
  input  logic [ADDRWIDTH-1:0]    raddr,
  output logic [NTAPS*DWIDTH-1:0] dout,
  output logic                    dout_valid
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int OW    = NTAPS * DWIDTH;

  logic [DWIDTH-1:0]    mem [DEPTH];
  logic                 wr_fire;
  logic [ADDRWIDTH-1:0] tap_addr [NTAPS];
  logic [DWIDTH-1:0]    tap_next [NTAPS];
  logic [OW-1:0]        s1_data;
  logic                 s1_valid;

  assign wr_fire = en & we;

  // Address sums truncate to ADDRWIDTH, so taps wrap past the top.
  // With BYPASS set, a tap hitting the write address sees di;
  // otherwise the non-blocking write leaves the old word visible.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      tap_addr[i] = raddr + ADDRWIDTH'(i);
      tap_next[i] = mem[tap_addr[i]];
      if ((BYPASS != 0) && wr_fire && (waddr == tap_addr[i])) begin
        tap_next[i] = di;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[waddr] <= di;
    end
  end

  // Taps load on every enabled edge; only s1_valid qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NTAPS; i++) begin
        s1_data[i*DWIDTH +: DWIDTH] <= tap_next[i];
      end
      s1_valid <= rd_en;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [OW-1:0] s2_data;
      logic          s2_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else if (en) begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign dout       = s2_data;
      assign dout_valid = s2_valid;
    end else begin : g_noreg
      assign dout       = s1_data;
      assign dout_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_rams_sdp_taps.sv
// Self-checking bench for rams_sdp_taps: four parameter variants
// share one stimulus stream and are compared against a word model.
module tb_rams_sdp_taps;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  waddr = '0;
  logic [3:0]  raddr = '0;
  logic [15:0] di = '0;

  logic [31:0] d0, d1, d3;
  logic [63:0] d2;
  logic        v0, v1, v2, v3;

  always #5 clk = ~clk;

  rams_sdp_taps #(.DWIDTH(16), .ADDRWIDTH(4), .NTAPS(2),
                  .OREG(1), .BYPASS(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
    .di(di), .rd_en(rd_en), .raddr(raddr),
    .dout(d0), .dout_valid(v0));

  rams_sdp_taps #(.DWIDTH(16), .ADDRWIDTH(4), .NTAPS(2),
                  .OREG(1), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
    .di(di), .rd_en(rd_en), .raddr(raddr),
    .dout(d1), .dout_valid(v1));

  rams_sdp_taps #(.DWIDTH(16), .ADDRWIDTH(4), .NTAPS(4),
                  .OREG(1), .BYPASS(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
    .di(di), .rd_en(rd_en), .raddr(raddr),
    .dout(d2), .dout_valid(v2));

  rams_sdp_taps #(.DWIDTH(16), .ADDRWIDTH(4), .NTAPS(2),
                  .OREG(0), .BYPASS(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
    .di(di), .rd_en(rd_en), .raddr(raddr),
    .dout(d3), .dout_valid(v3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: per enabled edge k, the word set a read at k would return.
  int nt_of[4]  = '{2, 2, 4, 2};
  int lat_of[4] = '{2, 2, 2, 1};
  int byp_of[4] = '{0, 1, 0, 0};

  int          n = 0;
  int          epoch = 0;
  logic [15:0] mm [16];
  bit          wr [16];
  logic [63:0] res [4][512];
  logic [3:0]  km [4][512];
  bit          vv [512];

  always @(posedge rst) epoch = n;

  always @(posedge clk) begin : model
    logic [3:0]  a;
    logic [63:0] r;
    logic [3:0]  k;
    if (rst) begin
      epoch = n;
    end else if (en) begin
      n = n + 1;
      vv[n] = rd_en;
      for (int p = 0; p < 4; p++) begin
        r = '0;
        k = '0;
        for (int i = 0; i < nt_of[p]; i++) begin
          a = raddr + 4'(i);
          if (byp_of[p] != 0 && we && waddr == a) begin
            r[i*16 +: 16] = di;
            k[i] = 1'b1;
          end else begin
            r[i*16 +: 16] = mm[a];
            k[i] = wr[a];
          end
        end
        res[p][n] = r;
        km[p][n]  = k;
      end
      if (we) begin
        mm[waddr] = di;
        wr[waddr] = 1'b1;
      end
    end
  end

  function automatic logic [63:0] dsel(input int p);
    case (p)
      0: return {32'b0, d0};
      1: return {32'b0, d1};
      2: return d2;
      default: return {32'b0, d3};
    endcase
  endfunction

  function automatic logic vsel(input int p);
    case (p)
      0: return v0;
      1: return v1;
      2: return v2;
      default: return v3;
    endcase
  endfunction

  always @(posedge clk) begin : compare
    int          idx;
    logic [63:0] got;
    logic [63:0] want;
    #1;
    for (int p = 0; p < 4; p++) begin
      idx = n - lat_of[p] + 1;
      got = dsel(p);
      if (idx <= epoch) begin
        chk($sformatf("u%0d idle dout", p), got, 64'h0);
        chk($sformatf("u%0d idle valid", p), 64'(vsel(p)), 64'h0);
      end else begin
        chk($sformatf("u%0d valid", p), 64'(vsel(p)), 64'(vv[idx]));
        if (vv[idx]) begin
          want = res[p][idx];
          for (int i = 0; i < nt_of[p]; i++) begin
            if (km[p][idx][i]) begin
              chk($sformatf("u%0d tap%0d", p, i),
                  64'(got[i*16 +: 16]), 64'(want[i*16 +: 16]));
            end
          end
        end
      end
    end
  end

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1;
    raddr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset d0", 64'(d0), 64'h0);
    chk("reset v0", 64'(v0), 64'h0);
    chk("reset d2", d2, 64'h0);
    rst = 1'b0;
    en  = 1'b1;

    for (int a = 0; a < 16; a++) begin
      we = 1'b1;
      waddr = 4'(a);
      di = 16'(a * 3);
      @(negedge clk);
    end
    we = 1'b0;

    rd(4'd4);
    chk("oreg0 rd4", 64'(d3), 64'h000f_000c);
    @(negedge clk);
    chk("rd4 data", 64'(d0), 64'h000f_000c);
    chk("rd4 valid", 64'(v0), 64'h1);
    @(negedge clk);
    chk("rd4 one-shot", 64'(v0), 64'h0);

    rd(4'd15);
    @(negedge clk);
    chk("wrap 15", 64'(d0), 64'h0000_002d);
    rd(4'd14);
    @(negedge clk);
    chk("wrap 4tap", d2, 64'h0003_0000_002d_002a);

    rd_en = 1'b1; raddr = 4'd7;
    we = 1'b1; waddr = 4'd8; di = 16'hAAAA;
    @(negedge clk);
    rd_en = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("coll old", 64'(d0), 64'h0018_0015);
    chk("coll byp", 64'(d1), 64'hAAAA_0015);
    rd(4'd8);
    @(negedge clk);
    chk("post coll u0", 64'(d0[15:0]), 64'hAAAA);
    chk("post coll u1", 64'(d1[15:0]), 64'hAAAA);
    we = 1'b1; waddr = 4'd8; di = 16'd24;
    @(negedge clk);
    we = 1'b0;

    rd_en = 1'b1; raddr = 4'd2;
    @(negedge clk);
    raddr = 4'd3;
    @(negedge clk);
    en = 1'b0; rd_en = 1'b0;
    we = 1'b1; waddr = 4'd5; di = 16'h1234;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall data", 64'(d0), 64'h0009_0006);
      chk("stall valid", 64'(v0), 64'h1);
    end
    en = 1'b1; we = 1'b0;
    rd_en = 1'b1; raddr = 4'd4;
    @(negedge clk);
    chk("stall r3", 64'(d0), 64'h000c_0009);
    rd_en = 1'b0;
    @(negedge clk);
    chk("stall r4", 64'(d0), 64'h000f_000c);
    @(negedge clk);
    chk("stall drain", 64'(v0), 64'h0);
    rd(4'd5);
    @(negedge clk);
    chk("en0 no write", 64'(d0), 64'h0012_000f);

    rd(4'd4);
    #2 rst = 1'b1;
    #1;
    chk("async rst d0", 64'(d0), 64'h0);
    chk("async rst v0", 64'(v0), 64'h0);
    chk("async rst d3", 64'(d3), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("no stale valid", 64'(v0), 64'h0);
    end
    rd(4'd4);
    @(negedge clk);
    chk("retained", 64'(d0), 64'h000f_000c);

    for (int r = 0; r < 16; r++) begin
      rd_en = 1'b1;
      raddr = 4'(r);
      @(negedge clk);
      chk("b2b valid", 64'(v3), 64'h1);
      chk("b2b tap0", 64'(d3[15:0]), 64'(16'(r * 3)));
    end
    rd_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
